argmax_collector: RTL and testbench

- Downstream consumer of the global controller and processing unit. Snoops final-layer (LAYER5) writes into the y buffer and computes the argmax class of each picture's 10 outputs.
- Stores one class index per picture in a small register file and pulses a per-picture result strobe.
- Raises all_done once MAX_NUMBER_PIC results are committed; host readback uses a registered read port.

---
 rtl/mlp_pkg.sv | 28 ++
 rtl/argmax_rf.sv | 49 ++++
 rtl/argmax_collector.sv | 205 ++++++++++++++++++++
 tb/tb_argmax_collector.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// mlp_pkg: constants and state codes shared by the MLP accelerator blocks.
// Holds the global controller state codes, the default y data width and the
// state enum of the argmax collector.
package mlp_pkg;

    // Default width of the y buffer data path (signed two's complement).
    localparam int DATA_W_DEFAULT = 16;

    // Global controller present-state codes; LAYER5 is the output layer.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        LAYER1 = 3'b001,
        LAYER2 = 3'b010,
        LAYER3 = 3'b011,
        LAYER4 = 3'b100,
        LAYER5 = 3'b101,
        DONE   = 3'b110
    } ctrl_state_e;

    // Argmax collector FSM states.
    typedef enum logic [1:0] {
        AM_IDLE   = 2'd0,
        AM_SCAN   = 2'd1,
        AM_COMMIT = 2'd2,
        AM_FULL   = 2'd3
    } am_state_e;

endpackage

// File: rtl/argmax_rf.sv
// argmax_rf: DEPTH x WIDTH register file, one synchronous write port and one
// registered read port. Reads of addresses at or beyond DEPTH return 0.
// The storage array is deliberately not reset; only the read register is.
module argmax_rf #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 4,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    wa_i,
    input  logic [WIDTH-1:0] wd_i,
    input  logic [AW-1:0]    ra_i,
    output logic [WIDTH-1:0] rd_o
);

    // One extra bit so DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic             wa_ok;
    logic             ra_ok;

    assign wa_ok = ({1'b0, wa_i} < DEPTH_EXT);
    assign ra_ok = ({1'b0, ra_i} < DEPTH_EXT);

    // Storage write: only in-range addresses are written.
    always_ff @(posedge clk) begin
        if (we_i && wa_ok) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    // Registered read: one cycle latency, out-of-range reads return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (ra_ok) begin
            rd_q <= mem_q[ra_i];
        end else begin
            rd_q <= '0;
        end
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/argmax_collector.sv
// argmax_collector: snoops output-layer writes into the y buffer, finds the
// argmax class of each picture's NUM_CLASS outputs, stores it per picture and
// raises all_done_o after MAX_NUMBER_PIC pictures.
// Optional build macro ARGMAX_SCORE_EN adds the winning score to the result
// strobe and a parallel score register file with its own readback port.
//
// Handshake: there is no back-pressure. A sample is accepted on any cycle with
// y_en && y_wen && ps == OUT_PS; result_valid_o is a one-cycle pulse and
// result_class_o/result_pic_o are valid in that same cycle.
module argmax_collector
    import mlp_pkg::*;
#(
    parameter int          MAX_NUMBER_PIC = 10,
    parameter int          NUM_CLASS      = 10,
    parameter int          DATA_W         = DATA_W_DEFAULT,
    parameter logic [2:0]  OUT_PS         = LAYER5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic [2:0]        ps,
    input  logic              y_en,
    input  logic              y_wen,
    input  logic [DATA_W-1:0] y_data,
    output logic              result_valid_o,
    output logic [3:0]        result_class_o,
    output logic [3:0]        result_pic_o,
    output logic [3:0]        pic_count_o,
    output logic              all_done_o,
    output logic              err_o,
    input  logic [3:0]        rd_addr_i,
    output logic [3:0]        rd_class_o
`ifdef ARGMAX_SCORE_EN
    ,
    output logic [DATA_W-1:0] result_score_o,
    output logic [DATA_W-1:0] rd_score_o
`endif
);

    // Class index, class counter and picture counter are 4 bits wide.
    if (NUM_CLASS < 1 || NUM_CLASS > 16 ||
        MAX_NUMBER_PIC < 1 || MAX_NUMBER_PIC > 16) begin : g_bad_cfg
        $error("argmax_collector: NUM_CLASS and MAX_NUMBER_PIC must be in 1..16");
    end

    localparam logic [3:0] LAST_CLS = 4'(NUM_CLASS - 1);
    localparam logic [3:0] LAST_PIC = 4'(MAX_NUMBER_PIC - 1);

    am_state_e                state_q;
    logic signed [DATA_W-1:0] max_q;
    logic [3:0]               idx_q;
    logic [3:0]               cls_cnt_q;
    logic [3:0]               pic_cnt_q;
    logic [3:0]               last_class_q;
    logic [3:0]               last_pic_q;
    logic                     all_done_q;
    logic                     err_q;

    logic                     in_out_layer;
    logic                     sample;
    logic                     commit_fire;
    logic signed [DATA_W-1:0] y_signed;

    assign in_out_layer = (ps == OUT_PS);
    assign sample       = y_en && y_wen && in_out_layer;
    assign y_signed     = $signed(y_data);

    // A commit happens in the COMMIT cycle unless a run clear overrides it.
    assign commit_fire  = (state_q == AM_COMMIT) && !clear_i;

    // Argmax FSM: collects samples, commits the winner, tracks run progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= AM_IDLE;
            max_q        <= '0;
            idx_q        <= '0;
            cls_cnt_q    <= '0;
            pic_cnt_q    <= '0;
            last_class_q <= '0;
            last_pic_q   <= '0;
            all_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else if (clear_i) begin
            // Run clear wins over any same-cycle sample or commit.
            state_q    <= AM_IDLE;
            cls_cnt_q  <= '0;
            pic_cnt_q  <= '0;
            all_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                AM_IDLE: begin
                    if (sample) begin
                        max_q     <= y_signed;
                        idx_q     <= '0;
                        cls_cnt_q <= 4'd1;
                        state_q   <= AM_SCAN;
                    end
                end

                AM_SCAN: begin
                    if (!in_out_layer) begin
                        // Controller left the output layer mid-picture:
                        // drop the partial picture and flag it.
                        err_q     <= 1'b1;
                        cls_cnt_q <= '0;
                        state_q   <= AM_IDLE;
                    end else if (sample) begin
                        // Strict compare: ties keep the lowest index.
                        if (y_signed > max_q) begin
                            max_q <= y_signed;
                            idx_q <= cls_cnt_q;
                        end
                        cls_cnt_q <= cls_cnt_q + 4'd1;
                        if (cls_cnt_q == LAST_CLS) begin
                            state_q <= AM_COMMIT;
                        end
                    end
                end

                AM_COMMIT: begin
                    last_class_q <= idx_q;
                    last_pic_q   <= pic_cnt_q;
                    pic_cnt_q    <= pic_cnt_q + 4'd1;
                    if (pic_cnt_q == LAST_PIC) begin
                        all_done_q <= 1'b1;
                        state_q    <= AM_FULL;
                        if (sample) begin
                            err_q <= 1'b1;
                        end
                    end else if (sample) begin
                        // First sample of the next picture arrives here.
                        max_q     <= y_signed;
                        idx_q     <= '0;
                        cls_cnt_q <= 4'd1;
                        state_q   <= AM_SCAN;
                    end else begin
                        state_q <= AM_IDLE;
                    end
                end

                AM_FULL: begin
                    if (sample) begin
                        err_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= AM_IDLE;
                end
            endcase
        end
    end

    assign result_valid_o = commit_fire;
    assign result_class_o = commit_fire ? idx_q : last_class_q;
    assign result_pic_o   = commit_fire ? pic_cnt_q : last_pic_q;
    assign pic_count_o    = pic_cnt_q;
    assign all_done_o     = all_done_q;
    assign err_o          = err_q;

    argmax_rf #(
        .DEPTH (MAX_NUMBER_PIC),
        .WIDTH (4),
        .AW    (4)
    ) u_class_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (commit_fire),
        .wa_i  (pic_cnt_q),
        .wd_i  (idx_q),
        .ra_i  (rd_addr_i),
        .rd_o  (rd_class_o)
    );

`ifdef ARGMAX_SCORE_EN
    logic [DATA_W-1:0] last_score_q;

    // Holds the last committed winning score between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_score_q <= '0;
        end else if (commit_fire) begin
            last_score_q <= max_q;
        end
    end

    assign result_score_o = commit_fire ? max_q : last_score_q;

    argmax_rf #(
        .DEPTH (MAX_NUMBER_PIC),
        .WIDTH (DATA_W),
        .AW    (4)
    ) u_score_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we_i  (commit_fire),
        .wa_i  (pic_cnt_q),
        .wd_i  (max_q),
        .ra_i  (rd_addr_i),
        .rd_o  (rd_score_o)
    );
`endif

endmodule

// File: tb/tb_argmax_collector.sv
// tb_argmax_collector: directed self-checking bench for argmax_collector.
module tb_argmax_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_i = 1'b0;
    logic [2:0]  ps = 3'd0;
    logic        y_en = 1'b0;
    logic        y_wen = 1'b0;
    logic [15:0] y_data = 16'd0;
    logic [3:0]  rd_addr_i = 4'd0;
    logic        result_valid_o;
    logic [3:0]  result_class_o;
    logic [3:0]  result_pic_o;
    logic [3:0]  pic_count_o;
    logic        all_done_o;
    logic        err_o;
    logic [3:0]  rd_class_o;
`ifdef ARGMAX_SCORE_EN
    logic [15:0] result_score_o;
    logic [15:0] rd_score_o;
`endif

    int          n_checks = 0;
    int          n_fail = 0;

    logic [15:0] pic_v [10];
    logic [3:0]  exp_cls [10];
    logic [3:0]  got_cls_q [$];
    logic [3:0]  got_pic_q [$];

    argmax_collector dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (clear_i),
        .ps             (ps),
        .y_en           (y_en),
        .y_wen          (y_wen),
        .y_data         (y_data),
        .result_valid_o (result_valid_o),
        .result_class_o (result_class_o),
        .result_pic_o   (result_pic_o),
        .pic_count_o    (pic_count_o),
        .all_done_o     (all_done_o),
        .err_o          (err_o),
        .rd_addr_i      (rd_addr_i),
        .rd_class_o     (rd_class_o)
`ifdef ARGMAX_SCORE_EN
        ,
        .result_score_o (result_score_o),
        .rd_score_o     (rd_score_o)
`endif
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Result monitor: records every strobe, sampled mid-cycle
    always @(negedge clk) begin
        if (result_valid_o === 1'b1) begin
            got_cls_q.push_back(result_class_o);
            got_pic_q.push_back(result_pic_o);
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) begin
            ps = 3'd5; y_en = 1'b1; y_wen = 1'b1; y_data = pic_v[i];
            cyc();
        end
        y_en = 1'b0; y_wen = 1'b0;
    endtask

    task automatic clear_mon();
        got_cls_q.delete();
        got_pic_q.delete();
    endtask

    task automatic load_pic_a();
        pic_v = '{16'd3, 16'hFFFF, 16'd7, 16'd2, 16'd7, 16'd0, 16'hFFFB, 16'd1, 16'd6, 16'd4};
    endtask

    task automatic load_pic_b();
        pic_v = '{16'hFFF7, 16'hFFFD, 16'hFFF8, 16'hFFFD, 16'hFFEC,
                  16'hFFFC, 16'hFFF9, 16'hFFFA, 16'hFFFB, 16'hFFF6};
    endtask

    task automatic load_pic_c();
        pic_v = '{16'hFFFE, 16'd5, 16'd5, 16'd9, 16'h8000, 16'h7FFF, 16'd0, 16'd1, 16'h7FFF, 16'd4};
    endtask

    // Tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({result_valid_o, result_class_o, result_pic_o, pic_count_o} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 0", {result_valid_o, result_class_o, result_pic_o, pic_count_o});
        end
        n_checks++;
        if ({all_done_o, err_o, rd_class_o} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_status: got %h expected 0", {all_done_o, err_o, rd_class_o});
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_picture();
        clear_mon();
        load_pic_a();
        send_n(10);
        n_checks++;
        if (result_valid_o !== 1'b1 || result_class_o !== 4'd2 || result_pic_o !== 4'd0) begin
            n_fail++;
            $display("FAIL single_strobe: got v=%0b cls=%0d pic=%0d expected v=1 cls=2 pic=0",
                     result_valid_o, result_class_o, result_pic_o);
        end
        n_checks++;
        if (pic_count_o !== 4'd0) begin
            n_fail++;
            $display("FAIL single_count_pre: got %0d expected 0", pic_count_o);
        end
        cyc();
        n_checks++;
        if (result_valid_o !== 1'b0 || pic_count_o !== 4'd1 || result_class_o !== 4'd2) begin
            n_fail++;
            $display("FAIL single_after: got v=%0b cnt=%0d cls=%0d expected v=0 cnt=1 cls=2",
                     result_valid_o, pic_count_o, result_class_o);
        end
        n_checks++;
        if (got_cls_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_pulses: got %0d expected 1", got_cls_q.size());
        end
    endtask

    task automatic test_other_layer_ignored();
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            ps = 3'd4; y_en = 1'b1; y_wen = 1'b1; y_data = 16'h7FFF;
            cyc();
        end
        y_en = 1'b0; y_wen = 1'b0;
        cyc();
        n_checks++;
        if (pic_count_o !== 4'd1 || err_o !== 1'b0 || got_cls_q.size() != 0) begin
            n_fail++;
            $display("FAIL layer4_ignored: got cnt=%0d err=%0b pulses=%0d expected cnt=1 err=0 pulses=0",
                     pic_count_o, err_o, got_cls_q.size());
        end
        load_pic_b();
        send_n(10);
        n_checks++;
        if (result_valid_o !== 1'b1 || result_class_o !== 4'd1 || result_pic_o !== 4'd1) begin
            n_fail++;
            $display("FAIL negative_strobe: got v=%0b cls=%0d pic=%0d expected v=1 cls=1 pic=1",
                     result_valid_o, result_class_o, result_pic_o);
        end
        cyc();
        n_checks++;
        if (pic_count_o !== 4'd2 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL negative_after: got cnt=%0d err=%0b expected cnt=2 err=0", pic_count_o, err_o);
        end
    endtask

    task automatic test_back_to_back();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        n_checks++;
        if (pic_count_o !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_clear: got cnt=%0d expected 0", pic_count_o);
        end
        clear_mon();
        // Winner at exp_cls[p] = 100, a tie of 100 at index 9, others -5..3.
        for (int p = 0; p < 10; p++) begin
            for (int i = 0; i < 10; i++) begin
                ps = 3'd5; y_en = 1'b1; y_wen = 1'b1;
                if (i == int'(exp_cls[p]) || i == 9) y_data = 16'd100;
                else y_data = 16'(i - 5);
                cyc();
            end
        end
        y_en = 1'b0; y_wen = 1'b0;
        n_checks++;
        if (result_valid_o !== 1'b1 || result_pic_o !== 4'd9 || result_class_o !== 4'd6 || all_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_last_strobe: got v=%0b pic=%0d cls=%0d done=%0b expected v=1 pic=9 cls=6 done=0",
                     result_valid_o, result_pic_o, result_class_o, all_done_o);
        end
        cyc();
        n_checks++;
        if (all_done_o !== 1'b1 || pic_count_o !== 4'd10 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done: got done=%0b cnt=%0d err=%0b expected done=1 cnt=10 err=0",
                     all_done_o, pic_count_o, err_o);
        end
        n_checks++;
        if (got_cls_q.size() != 10) begin
            n_fail++;
            $display("FAIL b2b_pulses: got %0d expected 10", got_cls_q.size());
        end else begin
            for (int p = 0; p < 10; p++) begin
                n_checks++;
                if (got_cls_q[p] !== exp_cls[p] || got_pic_q[p] !== 4'(p)) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got cls=%0d pic=%0d expected cls=%0d pic=%0d",
                             p, got_cls_q[p], got_pic_q[p], exp_cls[p], p);
                end
            end
        end
        for (int a = 0; a < 10; a++) begin
            rd_addr_i = 4'(a);
            cyc();
            n_checks++;
            if (rd_class_o !== exp_cls[a]) begin
                n_fail++;
                $display("FAIL readback[%0d]: got %0d expected %0d", a, rd_class_o, exp_cls[a]);
            end
        end
        rd_addr_i = 4'd12;
        cyc();
        n_checks++;
        if (rd_class_o !== 4'd0) begin
            n_fail++;
            $display("FAIL readback_oob: got %0d expected 0", rd_class_o);
        end
    endtask

    task automatic test_full_and_clear();
        clear_mon();
        ps = 3'd5; y_en = 1'b1; y_wen = 1'b1; y_data = 16'd1;
        cyc();
        y_en = 1'b0; y_wen = 1'b0;
        cyc();
        n_checks++;
        if (err_o !== 1'b1 || all_done_o !== 1'b1 || pic_count_o !== 4'd10 || got_cls_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_sample: got err=%0b done=%0b cnt=%0d pulses=%0d expected err=1 done=1 cnt=10 pulses=0",
                     err_o, all_done_o, pic_count_o, got_cls_q.size());
        end
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        n_checks++;
        if (all_done_o !== 1'b0 || err_o !== 1'b0 || pic_count_o !== 4'd0 || result_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_status: got done=%0b err=%0b cnt=%0d v=%0b expected all 0",
                     all_done_o, err_o, pic_count_o, result_valid_o);
        end
        rd_addr_i = 4'd4;
        cyc();
        n_checks++;
        if (rd_class_o !== exp_cls[4]) begin
            n_fail++;
            $display("FAIL clear_keeps_rf: got %0d expected %0d", rd_class_o, exp_cls[4]);
        end
    endtask

    task automatic test_abort();
        clear_mon();
        load_pic_c();
        send_n(5);
        ps = 3'd1;
        cyc();
        cyc();
        n_checks++;
        if (err_o !== 1'b1 || pic_count_o !== 4'd0 || got_cls_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort: got err=%0b cnt=%0d pulses=%0d expected err=1 cnt=0 pulses=0",
                     err_o, pic_count_o, got_cls_q.size());
        end
        send_n(10);
        n_checks++;
        if (result_valid_o !== 1'b1 || result_class_o !== 4'd5 || result_pic_o !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_next_strobe: got v=%0b cls=%0d pic=%0d expected v=1 cls=5 pic=0",
                     result_valid_o, result_class_o, result_pic_o);
        end
        cyc();
        n_checks++;
        if (pic_count_o !== 4'd1) begin
            n_fail++;
            $display("FAIL abort_next_count: got %0d expected 1", pic_count_o);
        end
    endtask

    task automatic test_clear_in_commit();
        clear_mon();
        load_pic_a();
        send_n(10);
        clear_i = 1'b1;
        #1;
        n_checks++;
        if (result_valid_o !== 1'b0 || result_class_o !== 4'd5) begin
            n_fail++;
            $display("FAIL clear_commit_strobe: got v=%0b cls=%0d expected v=0 cls=5", result_valid_o, result_class_o);
        end
        cyc();
        clear_i = 1'b0;
        n_checks++;
        if (pic_count_o !== 4'd0 || got_cls_q.size() != 0) begin
            n_fail++;
            $display("FAIL clear_commit_count: got cnt=%0d pulses=%0d expected cnt=0 pulses=0",
                     pic_count_o, got_cls_q.size());
        end
        rd_addr_i = 4'd1;
        cyc();
        n_checks++;
        if (rd_class_o !== exp_cls[1]) begin
            n_fail++;
            $display("FAIL clear_commit_rf: got %0d expected %0d", rd_class_o, exp_cls[1]);
        end
    endtask

    task automatic test_async_reset();
        load_pic_b();
        send_n(10);
        cyc();
        rd_addr_i = 4'd0;
        cyc();
        n_checks++;
        if (pic_count_o !== 4'd1 || rd_class_o !== 4'd1) begin
            n_fail++;
            $display("FAIL areset_setup: got cnt=%0d rd=%0d expected cnt=1 rd=1", pic_count_o, rd_class_o);
        end
        load_pic_a();
        send_n(4);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({result_valid_o, result_class_o, result_pic_o, pic_count_o, all_done_o, err_o, rd_class_o} !== 19'd0) begin
            n_fail++;
            $display("FAIL areset_outputs: got %h expected 0",
                     {result_valid_o, result_class_o, result_pic_o, pic_count_o, all_done_o, err_o, rd_class_o});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        send_n(10);
        n_checks++;
        if (result_valid_o !== 1'b1 || result_class_o !== 4'd2 || result_pic_o !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_fresh: got v=%0b cls=%0d pic=%0d expected v=1 cls=2 pic=0",
                     result_valid_o, result_class_o, result_pic_o);
        end
        cyc();
        n_checks++;
        if (pic_count_o !== 4'd1 || got_cls_q.size() != 1) begin
            n_fail++;
            $display("FAIL areset_fresh_count: got cnt=%0d pulses=%0d expected cnt=1 pulses=1",
                     pic_count_o, got_cls_q.size());
        end
    endtask

    // Sequence and final report
    initial begin
        exp_cls = '{4'd3, 4'd0, 4'd7, 4'd4, 4'd1, 4'd8, 4'd5, 4'd2, 4'd9, 4'd6};
        test_reset();
        test_single_picture();
        test_other_layer_ignored();
        test_back_to_back();
        test_full_and_clear();
        test_abort();
        test_clear_in_commit();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
